// File: rtl/pipe_pkg.sv
// Shared types and defaults for the IF/ID skid stage.
// Occupancy states and default payload widths and NOP encoding.
package pipe_pkg;
  localparam int PC_W_D = 16;
  localparam int INST_W_D = 16;
  localparam logic [15:0] NOP_INST_D = 16'h0800;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;
endpackage

// File: rtl/pipe_entry_reg.sv
// One payload slot {pc, pc_inc, inst} of the IF/ID stage.
// Clear wins over load and restores the NOP payload.
module pipe_entry_reg
  import pipe_pkg::*;
#(
  parameter int PC_W = PC_W_D,
  parameter int INST_W = INST_W_D,
  parameter logic [INST_W-1:0] NOP_INST = NOP_INST_D
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_load,
  input  logic              i_clear,
  input  logic [PC_W-1:0]   i_pc,
  input  logic [PC_W-1:0]   i_pc_inc,
  input  logic [INST_W-1:0] i_inst,
  output logic [PC_W-1:0]   o_pc,
  output logic [PC_W-1:0]   o_pc_inc,
  output logic [INST_W-1:0] o_inst
);
  logic [PC_W-1:0]   r_pc;
  logic [PC_W-1:0]   r_pc_inc;
  logic [INST_W-1:0] r_inst;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pc     <= '0;
      r_pc_inc <= '0;
      r_inst   <= NOP_INST;
    end else if (i_clear) begin
      r_pc     <= '0;
      r_pc_inc <= '0;
      r_inst   <= NOP_INST;
    end else if (i_load) begin
      r_pc     <= i_pc;
      r_pc_inc <= i_pc_inc;
      r_inst   <= i_inst;
    end
  end

  assign o_pc     = r_pc;
  assign o_pc_inc = r_pc_inc;
  assign o_inst   = r_inst;
endmodule

// File: rtl/if_id_skid_stage.sv
// IF/ID stage: main + skid entries, registered ready, flush with
// saturating count of discarded beats.
module if_id_skid_stage
  import pipe_pkg::*;
#(
  parameter int PC_W = PC_W_D,
  parameter int INST_W = INST_W_D,
  parameter logic [INST_W-1:0] NOP_INST = NOP_INST_D,
  parameter int CNT_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PC_W-1:0]   in_pc,
  input  logic [PC_W-1:0]   in_pc_inc,
  input  logic [INST_W-1:0] in_inst,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [PC_W-1:0]   out_pc,
  output logic [PC_W-1:0]   out_pc_inc,
  output logic [INST_W-1:0] out_inst,
  output logic [CNT_W-1:0]  flush_cnt
);
  state_t r_state, w_next;
  logic [CNT_W-1:0] r_cnt;

  logic w_in_fire, w_out_fire;
  logic w_main_ld, w_main_clr, w_main_src_skid;
  logic w_skid_ld, w_skid_clr;
  logic [PC_W-1:0]   w_skid_pc, w_skid_pc_inc;
  logic [INST_W-1:0] w_skid_inst;
  logic [PC_W-1:0]   w_main_pc_d, w_main_pc_inc_d;
  logic [INST_W-1:0] w_main_inst_d;
  logic [1:0]        w_occ, w_disc;
  logic [CNT_W:0]    w_sum;

  assign in_ready   = (r_state != FULL);
  assign out_valid  = (r_state != EMPTY);
  assign w_in_fire  = in_valid & in_ready;
  assign w_out_fire = out_valid & out_ready;

  always_comb begin
    w_next          = r_state;
    w_main_ld       = 1'b0;
    w_main_clr      = 1'b0;
    w_main_src_skid = 1'b0;
    w_skid_ld       = 1'b0;
    w_skid_clr      = 1'b0;
    if (flush) begin
      w_next     = EMPTY;
      w_main_clr = 1'b1;
      w_skid_clr = 1'b1;
    end else begin
      unique case (r_state)
        EMPTY: if (w_in_fire) begin
          w_next    = ONE;
          w_main_ld = 1'b1;
        end
        ONE: unique case (1'b1)
          w_in_fire && w_out_fire: w_main_ld = 1'b1;
          w_in_fire && !w_out_fire: begin
            w_next    = FULL;
            w_skid_ld = 1'b1;
          end
          !w_in_fire && w_out_fire: begin
            w_next     = EMPTY;
            w_main_clr = 1'b1;
          end
          default: ;
        endcase
        FULL: if (w_out_fire) begin
          w_next          = ONE;
          w_main_ld       = 1'b1;
          w_main_src_skid = 1'b1;
          w_skid_clr      = 1'b1;
        end
        default: w_next = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= EMPTY;
    else      r_state <= w_next;
  end

  // The skid beat is always older than the incoming one, so it refills main first.
  assign w_main_pc_d     = w_main_src_skid ? w_skid_pc : in_pc;
  assign w_main_pc_inc_d = w_main_src_skid ? w_skid_pc_inc : in_pc_inc;
  assign w_main_inst_d   = w_main_src_skid ? w_skid_inst : in_inst;

  pipe_entry_reg #(
    .PC_W(PC_W), .INST_W(INST_W), .NOP_INST(NOP_INST)
  ) u_main (
    .clk(clk), .rst(rst),
    .i_load(w_main_ld), .i_clear(w_main_clr),
    .i_pc(w_main_pc_d), .i_pc_inc(w_main_pc_inc_d),
    .i_inst(w_main_inst_d),
    .o_pc(out_pc), .o_pc_inc(out_pc_inc), .o_inst(out_inst)
  );

  pipe_entry_reg #(
    .PC_W(PC_W), .INST_W(INST_W), .NOP_INST(NOP_INST)
  ) u_skid (
    .clk(clk), .rst(rst),
    .i_load(w_skid_ld), .i_clear(w_skid_clr),
    .i_pc(in_pc), .i_pc_inc(in_pc_inc), .i_inst(in_inst),
    .o_pc(w_skid_pc), .o_pc_inc(w_skid_pc_inc),
    .o_inst(w_skid_inst)
  );

  assign w_occ = (r_state == FULL) ? 2'd2 :
                 (r_state == ONE)  ? 2'd1 : 2'd0;
  assign w_disc = w_occ - {1'b0, w_out_fire}
                + {1'b0, w_in_fire};
  assign w_sum = {1'b0, r_cnt}
               + {{(CNT_W-1){1'b0}}, w_disc};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)       r_cnt <= '0;
    else if (flush) r_cnt <= w_sum[CNT_W] ? '1 : w_sum[CNT_W-1:0];
  end

  assign flush_cnt = r_cnt;
endmodule

// File: tb/tb_if_id_skid_stage.sv
// Bench for if_id_skid_stage: directed table, stream, saturation,
// async reset and random traffic against a queue model.
module tb_if_id_skid_stage;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] in_pc = '0;
  logic [15:0] in_pc_inc = '0;
  logic [15:0] in_inst = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] out_pc;
  logic [15:0] out_pc_inc;
  logic [15:0] out_inst;
  logic [7:0]  flush_cnt;

  if_id_skid_stage dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_pc(in_pc), .in_pc_inc(in_pc_inc), .in_inst(in_inst),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_pc_inc(out_pc_inc), .out_inst(out_inst),
    .flush_cnt(flush_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] pc;
    logic [15:0] pc_inc;
    logic [15:0] inst;
  } beat_t;

  typedef struct {
    logic        f;
    logic        v;
    logic [15:0] inst;
    logic        r;
    logic        e_valid;
    logic        e_ready;
    logic [15:0] e_inst;
    logic [7:0]  e_cnt;
  } vec_t;

  beat_t m_q[$];
  int    m_cnt = 0;
  int    n_tests = 0;
  int    n_fail = 0;

  task automatic chk(input string n, input logic [31:0] a,
                     input logic [31:0] e);
    n_tests++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", n, a, e);
    end
  endtask

  // Queue model: beats held = queue contents, front is visible.
  task automatic step(input logic f, input logic v,
                      input logic [15:0] pc, input logic [15:0] inst,
                      input logic r);
    beat_t b;
    bit ir, ov, inf, of;
    int d;
    flush = f; in_valid = v; in_pc = pc;
    in_pc_inc = pc + 16'd2; in_inst = inst; out_ready = r;
    b.pc = pc; b.pc_inc = pc + 16'd2; b.inst = inst;
    ir = (m_q.size() < 2);
    ov = (m_q.size() > 0);
    inf = v && ir;
    of = ov && r;
    if (f) begin
      d = m_q.size() - int'(of) + int'(inf);
      m_cnt = (m_cnt + d > 255) ? 255 : m_cnt + d;
      m_q.delete();
    end else begin
      if (of) void'(m_q.pop_front());
      if (inf) m_q.push_back(b);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic check_model(input string tag);
    chk({tag, "_valid"}, 32'(out_valid), 32'(m_q.size() > 0));
    chk({tag, "_ready"}, 32'(in_ready), 32'(m_q.size() < 2));
    chk({tag, "_cnt"}, 32'(flush_cnt), 32'(m_cnt));
    if (m_q.size() > 0) begin
      chk({tag, "_inst"}, 32'(out_inst), 32'(m_q[0].inst));
      chk({tag, "_pc"}, 32'(out_pc), 32'(m_q[0].pc));
      chk({tag, "_pcinc"}, 32'(out_pc_inc), 32'(m_q[0].pc_inc));
    end else begin
      chk({tag, "_inst"}, 32'(out_inst), 32'h0800);
      chk({tag, "_pc"}, 32'(out_pc), 32'h0);
      chk({tag, "_pcinc"}, 32'(out_pc_inc), 32'h0);
    end
  endtask

  task automatic do_reset();
    rst = 1'b0;
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    m_q.delete();
    m_cnt = 0;
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  vec_t tbl[14];

  initial begin
    tbl[0]  = '{0, 1, 16'h1234, 1, 1, 1, 16'h1234, 0};
    tbl[1]  = '{0, 0, 16'h0000, 1, 0, 1, 16'h0800, 0};
    tbl[2]  = '{0, 1, 16'hA001, 0, 1, 1, 16'hA001, 0};
    tbl[3]  = '{0, 1, 16'hA002, 0, 1, 0, 16'hA001, 0};
    tbl[4]  = '{0, 1, 16'hA003, 0, 1, 0, 16'hA001, 0};
    tbl[5]  = '{0, 1, 16'hA003, 1, 1, 1, 16'hA002, 0};
    tbl[6]  = '{0, 1, 16'hA003, 1, 1, 1, 16'hA003, 0};
    tbl[7]  = '{0, 0, 16'h0000, 1, 0, 1, 16'h0800, 0};
    tbl[8]  = '{0, 1, 16'hB001, 0, 1, 1, 16'hB001, 0};
    tbl[9]  = '{0, 1, 16'hB002, 0, 1, 0, 16'hB001, 0};
    tbl[10] = '{1, 1, 16'hB003, 0, 0, 1, 16'h0800, 2};
    tbl[11] = '{1, 0, 16'h0000, 1, 0, 1, 16'h0800, 2};
    tbl[12] = '{0, 1, 16'hC001, 1, 1, 1, 16'hC001, 2};
    tbl[13] = '{1, 1, 16'hC002, 1, 0, 1, 16'h0800, 3};

    do_reset();
    chk("rst_valid", 32'(out_valid), 32'h0);
    chk("rst_ready", 32'(in_ready), 32'h1);
    chk("rst_inst", 32'(out_inst), 32'h0800);
    chk("rst_pc", 32'(out_pc), 32'h0);
    chk("rst_pcinc", 32'(out_pc_inc), 32'h0);
    chk("rst_cnt", 32'(flush_cnt), 32'h0);

    for (int i = 0; i < 14; i++) begin
      step(tbl[i].f, tbl[i].v, tbl[i].inst, tbl[i].inst, tbl[i].r);
      chk($sformatf("tbl%0d_valid", i), 32'(out_valid), 32'(tbl[i].e_valid));
      chk($sformatf("tbl%0d_ready", i), 32'(in_ready), 32'(tbl[i].e_ready));
      chk($sformatf("tbl%0d_inst", i), 32'(out_inst), 32'(tbl[i].e_inst));
      chk($sformatf("tbl%0d_cnt", i), 32'(flush_cnt), 32'(tbl[i].e_cnt));
    end

    // Back-to-back stream: one beat per cycle, ready never drops.
    do_reset();
    for (int i = 0; i < 8; i++) begin
      step(0, 1, 16'(16'h100 + 2 * i), 16'(16'h5000 + i), 1);
      chk($sformatf("strm%0d_inst", i), 32'(out_inst), 32'(16'h5000 + i));
      chk($sformatf("strm%0d_pc", i), 32'(out_pc), 32'(16'h100 + 2 * i));
      chk($sformatf("strm%0d_rdy", i), 32'(in_ready), 32'h1);
    end
    step(0, 0, 16'h0, 16'h0, 1);
    chk("strm_end_valid", 32'(out_valid), 32'h0);

    // Counter saturation: each pair of cycles discards two beats.
    do_reset();
    for (int i = 0; i < 127; i++) begin
      step(0, 1, 16'h0, 16'h7777, 0);
      step(1, 1, 16'h0, 16'h7778, 0);
    end
    chk("sat_254", 32'(flush_cnt), 32'd254);
    step(0, 1, 16'h0, 16'h7777, 0);
    step(1, 1, 16'h0, 16'h7778, 0);
    chk("sat_255", 32'(flush_cnt), 32'd255);
    step(0, 1, 16'h0, 16'h7777, 0);
    step(1, 1, 16'h0, 16'h7778, 0);
    chk("sat_hold", 32'(flush_cnt), 32'd255);
    check_model("sat_model");

    // Async reset while FULL and stalled.
    step(0, 1, 16'h20, 16'hD001, 0);
    step(0, 1, 16'h22, 16'hD002, 0);
    chk("full_ready", 32'(in_ready), 32'h0);
    #2;
    rst = 1'b0;
    #1;
    chk("arst_valid", 32'(out_valid), 32'h0);
    chk("arst_ready", 32'(in_ready), 32'h1);
    chk("arst_inst", 32'(out_inst), 32'h0800);
    chk("arst_pc", 32'(out_pc), 32'h0);
    chk("arst_cnt", 32'(flush_cnt), 32'h0);
    m_q.delete();
    m_cnt = 0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    check_model("post_arst");

    // Random traffic against the queue model.
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 15) == 0),
           ($urandom_range(0, 9) < 7),
           16'($urandom), 16'($urandom),
           ($urandom_range(0, 9) < 6));
      check_model($sformatf("rnd%0d", i));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
